sram_like_arbiter: RTL and testbench

//  Shares one SRAM-like master port between the IF-stage instruction requester and the
//  EXE-stage data requester. Arbitrates req/addr_ok per cycle, records the owner of every

---
 rtl/sram_like_arbiter_pkg.sv | 20 ++
 rtl/sram_like_arbiter_if.sv | 25 ++
 rtl/sram_like_arbiter_tag_fifo.sv | 65 ++++++
 rtl/sram_like_arbiter.sv | 96 +++++++++
 tb/tb_sram_like_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared constants and types for the SRAM-like instruction/data port arbiter.
// Tag values identify which requester owns an outstanding memory transaction.
package sram_like_arbiter_pkg;

   localparam logic SRC_INST = 1'b0;
   localparam logic SRC_DATA = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } sram_req_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response bundle. req/addr_ok form the request handshake
// (accepted on a cycle where both are high); data_ok is a one-cycle response strobe.
interface sram_like_arbiter_if;

   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );

endinterface

// File: rtl/sram_like_arbiter_tag_fifo.sv
// In-order 1-bit owner tag FIFO; one entry per accepted, not yet answered request.
// Push when full and pop when empty are ignored so the count can never leave 0..DEPTH.
module arb_tag_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push_i,
   input  logic tag_i,
   input  logic pop_i,
   output logic head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = tag_i;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access:
// data-first grant with starvation relief for inst, owner tags routed back in order.
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int OUTSTANDING  = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   sram_like_arbiter_if.slave         inst_sram,
   sram_like_arbiter_if.slave         data_sram,
   sram_like_arbiter_if.master        mem
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic          fifo_full, fifo_empty, fifo_head;
   logic          grant_inst, grant_data, starve_hit;
   logic          accept, inst_accept, data_accept, resp_pop;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   sram_req_t     inst_req_s, data_req_s, mem_req_s;

   assign inst_req_s = '{wr: inst_sram.wr, size: inst_sram.size, wstrb: inst_sram.wstrb,
                         addr: inst_sram.addr, wdata: inst_sram.wdata};
   assign data_req_s = '{wr: data_sram.wr, size: data_sram.size, wstrb: data_sram.wstrb,
                         addr: data_sram.addr, wdata: data_sram.wdata};

   // A full FIFO blocks grant even if a response frees a slot this same cycle.
   assign starve_hit = (starve_cnt_q == STARVE_MAX) & inst_sram.req;
   assign grant_data = ~reset & ~fifo_full & data_sram.req & ~starve_hit;
   assign grant_inst = ~reset & ~fifo_full & inst_sram.req & ~grant_data;

   always_comb begin
      mem_req_s = '0;
      if (grant_data) begin
         mem_req_s = data_req_s;
      end else if (grant_inst) begin
         mem_req_s = inst_req_s;
      end
   end

   assign mem.req   = grant_inst | grant_data;
   assign mem.wr    = mem_req_s.wr;
   assign mem.size  = mem_req_s.size;
   assign mem.wstrb = mem_req_s.wstrb;
   assign mem.addr  = mem_req_s.addr;
   assign mem.wdata = mem_req_s.wdata;

   assign inst_sram.addr_ok = grant_inst & mem.addr_ok;
   assign data_sram.addr_ok = grant_data & mem.addr_ok;

   assign accept      = mem.req & mem.addr_ok;
   assign inst_accept = accept & grant_inst;
   assign data_accept = accept & grant_data;

   // Responses are answered in acceptance order; a stray data_ok with no tag is dropped.
   assign resp_pop = ~reset & mem.data_ok & ~fifo_empty;

   assign inst_sram.data_ok = resp_pop & (fifo_head == SRC_INST);
   assign data_sram.data_ok = resp_pop & (fifo_head == SRC_DATA);
   assign inst_sram.rdata   = mem.rdata;
   assign data_sram.rdata   = mem.rdata;

   arb_tag_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (accept),
      .tag_i   (grant_data ? SRC_DATA : SRC_INST),
      .pop_i   (resp_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (inst_accept || !inst_sram.req) begin
         starve_cnt_d = '0;
      end else if (data_accept && starve_cnt_q != STARVE_MAX) begin
         starve_cnt_d = starve_cnt_q + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: grant priority, in-order routing,
// FIFO-full back-pressure, starvation relief and reset discard.
module tb_sram_like_arbiter;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   sram_like_arbiter_if inst_if ();
   sram_like_arbiter_if data_if ();
   sram_like_arbiter_if mem_if ();

   sram_like_arbiter #(
      .OUTSTANDING  (4),
      .STARVE_LIMIT (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .inst_sram (inst_if),
      .data_sram (data_if),
      .mem       (mem_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2; inst_if.wstrb = 4'hf;
      inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
      data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd2; data_if.wstrb = 4'hf;
      data_if.addr = 32'h0; data_if.wdata = 32'h0;
      mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      step();
      step();
      inst_if.req = 1'b1; data_if.req = 1'b1;
      mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1;
      settle();
      checks++; if (mem_if.req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_if.req); end
      checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b00) begin errors++; $display("FAIL reset_addr_ok got=%b exp=00", {inst_if.addr_ok, data_if.addr_ok}); end
      checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin errors++; $display("FAIL reset_data_ok got=%b exp=00", {inst_if.data_ok, data_if.data_ok}); end
      step();
      idle();
      reset = 1'b0;
   endtask

   task automatic test_single_inst();
      step();
      inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0000; mem_if.addr_ok = 1'b1;
      settle();
      checks++; if (inst_if.addr_ok !== 1'b1) begin errors++; $display("FAIL single_inst_addr_ok got=%b exp=1", inst_if.addr_ok); end
      checks++; if (mem_if.addr !== 32'h1c00_0000) begin errors++; $display("FAIL single_mem_addr got=%h exp=1c000000", mem_if.addr); end
      step();
      idle();
      mem_if.data_ok = 1'b1; mem_if.rdata = 32'h1234_5678;
      settle();
      checks++; if (inst_if.data_ok !== 1'b1) begin errors++; $display("FAIL single_inst_data_ok got=%b exp=1", inst_if.data_ok); end
      checks++; if (inst_if.rdata !== 32'h1234_5678) begin errors++; $display("FAIL single_inst_rdata got=%h exp=12345678", inst_if.rdata); end
      checks++; if (data_if.data_ok !== 1'b0) begin errors++; $display("FAIL single_data_data_ok got=%b exp=0", data_if.data_ok); end
      step();
      idle();
   endtask

   task automatic test_priority();
      inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0040;
      data_if.req = 1'b1; data_if.addr = 32'h8000_1000; data_if.wr = 1'b1; data_if.wdata = 32'hcafe_f00d;
      mem_if.addr_ok = 1'b1;
      settle();
      checks++; if (mem_if.addr !== 32'h8000_1000) begin errors++; $display("FAIL prio_mem_addr got=%h exp=80001000", mem_if.addr); end
      checks++; if ({mem_if.wr, mem_if.wdata} !== {1'b1, 32'hcafe_f00d}) begin errors++; $display("FAIL prio_mem_wdata got=%b/%h exp=1/cafef00d", mem_if.wr, mem_if.wdata); end
      checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01) begin errors++; $display("FAIL prio_addr_ok got=%b exp=01", {inst_if.addr_ok, data_if.addr_ok}); end
      step();
      idle();
      mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0000_00aa;
      settle();
      checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b01) begin errors++; $display("FAIL prio_data_ok got=%b exp=01", {inst_if.data_ok, data_if.data_ok}); end
      step();
      idle();
   endtask

   task automatic test_order();
      logic [2:0] exp_own;
      exp_own = 3'b010;
      mem_if.addr_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inst_if.req = ~exp_own[i]; data_if.req = exp_own[i];
         inst_if.addr = 32'h1c00_0100 + 32'(i); data_if.addr = 32'h8000_0100 + 32'(i);
         settle();
         checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== {~exp_own[i], exp_own[i]}) begin errors++; $display("FAIL order_accept%0d got=%b exp=%b", i, {inst_if.addr_ok, data_if.addr_ok}, {~exp_own[i], exp_own[i]}); end
         step();
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         mem_if.data_ok = 1'b1; mem_if.rdata = 32'h5000_0000 + 32'(i);
         settle();
         checks++; if ({inst_if.data_ok, data_if.data_ok} !== {~exp_own[i], exp_own[i]}) begin errors++; $display("FAIL order_resp%0d got=%b exp=%b", i, {inst_if.data_ok, data_if.data_ok}, {~exp_own[i], exp_own[i]}); end
         step();
      end
      idle();
      mem_if.data_ok = 1'b1;
      settle();
      checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin errors++; $display("FAIL order_extra_resp got=%b exp=00", {inst_if.data_ok, data_if.data_ok}); end
      step();
      idle();
   endtask

   task automatic test_full();
      logic [3:0] exp_own;
      exp_own = 4'b1000;
      inst_if.req = 1'b1; mem_if.addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         inst_if.addr = 32'h1c00_0200 + 32'(4 * i);
         settle();
         checks++; if (inst_if.addr_ok !== 1'b1) begin errors++; $display("FAIL full_fill%0d got=%b exp=1", i, inst_if.addr_ok); end
         step();
      end
      data_if.req = 1'b1; data_if.addr = 32'h8000_0200;
      settle();
      checks++; if ({mem_if.req, inst_if.addr_ok, data_if.addr_ok} !== 3'b000) begin errors++; $display("FAIL full_block got=%b exp=000", {mem_if.req, inst_if.addr_ok, data_if.addr_ok}); end
      step();
      mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0000_0001;
      settle();
      checks++; if ({mem_if.req, inst_if.data_ok, data_if.data_ok} !== 3'b010) begin errors++; $display("FAIL full_pop_same_cycle got=%b exp=010", {mem_if.req, inst_if.data_ok, data_if.data_ok}); end
      step();
      mem_if.data_ok = 1'b0;
      settle();
      checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01) begin errors++; $display("FAIL full_resume got=%b exp=01", {inst_if.addr_ok, data_if.addr_ok}); end
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         mem_if.data_ok = 1'b1;
         settle();
         checks++; if ({inst_if.data_ok, data_if.data_ok} !== {~exp_own[i], exp_own[i]}) begin errors++; $display("FAIL full_drain%0d got=%b exp=%b", i, {inst_if.data_ok, data_if.data_ok}, {~exp_own[i], exp_own[i]}); end
         step();
      end
      idle();
   endtask

   task automatic test_starve();
      inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0300;
      data_if.req = 1'b1; data_if.addr = 32'h8000_0300;
      mem_if.addr_ok = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         mem_if.data_ok = (k > 1);
         settle();
         if (k == 9) begin
            checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b10) begin errors++; $display("FAIL starve_grant%0d got=%b exp=10", k, {inst_if.addr_ok, data_if.addr_ok}); end
         end else begin
            checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01) begin errors++; $display("FAIL starve_grant%0d got=%b exp=01", k, {inst_if.addr_ok, data_if.addr_ok}); end
         end
         if (k == 10) begin
            checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b10) begin errors++; $display("FAIL starve_resp%0d got=%b exp=10", k, {inst_if.data_ok, data_if.data_ok}); end
         end else if (k > 1) begin
            checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b01) begin errors++; $display("FAIL starve_resp%0d got=%b exp=01", k, {inst_if.data_ok, data_if.data_ok}); end
         end
         step();
      end
      idle();
      mem_if.data_ok = 1'b1;
      settle();
      checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b01) begin errors++; $display("FAIL starve_drain got=%b exp=01", {inst_if.data_ok, data_if.data_ok}); end
      step();
      idle();
   endtask

   task automatic test_reset_mid();
      mem_if.addr_ok = 1'b1;
      inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0400;
      settle();
      checks++; if (inst_if.addr_ok !== 1'b1) begin errors++; $display("FAIL rst_mid_inst got=%b exp=1", inst_if.addr_ok); end
      step();
      inst_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h8000_0400;
      settle();
      checks++; if (data_if.addr_ok !== 1'b1) begin errors++; $display("FAIL rst_mid_data got=%b exp=1", data_if.addr_ok); end
      step();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mem_if.data_ok = 1'b1; mem_if.rdata = 32'hdead_0000 + 32'(i);
         settle();
         checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin errors++; $display("FAIL rst_mid_stray%0d got=%b exp=00", i, {inst_if.data_ok, data_if.data_ok}); end
         step();
      end
      idle();
      inst_if.req = 1'b1; mem_if.addr_ok = 1'b1;
      settle();
      checks++; if (inst_if.addr_ok !== 1'b1) begin errors++; $display("FAIL rst_mid_regrant got=%b exp=1", inst_if.addr_ok); end
      step();
      idle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_inst();
      test_priority();
      test_order();
      test_full();
      test_starve();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
